// File: rtl/cmd_issuer_pkg.sv
// Shared opcode and request definitions for the Life core command issuer.
// The core decodes only the low two opcode bits. Bit 2 is carried through unchanged.
package cmd_issuer_pkg;

  typedef enum logic [1:0] {
    CMD_IDLE      = 2'd0,
    CMD_SOLVE     = 2'd1,
    CMD_READ_CELL = 2'd2,
    CMD_SEED      = 2'd3
  } opcode_e;

  // Read-cell argument layout: column in [19:10], row in [9:0].
  typedef struct packed {
    logic [11:0] rsvd;
    logic [9:0]  column;
    logic [9:0]  row;
  } cell_arg_t;

  typedef struct packed {
    logic [2:0]  cmd;
    logic [31:0] arg0;
  } req_t;

  function automatic logic is_read_cell(input logic [2:0] op);
    return op[1:0] == CMD_READ_CELL;
  endfunction

endpackage

// File: rtl/cmd_issuer_fifo.sv
// Request FIFO for cmd_issuer: synchronous, power-of-two depth, combinational head.
// A push is dropped when the FIFO is full. A pop is dropped when it is empty.
module cmd_fifo #(
  parameter int unsigned WIDTH = 35,
  parameter int unsigned DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_head    = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/cmd_issuer.sv
// Host-side initiator for the Life core control port: queues requests and issues one at a time.
// Optional watchdog on WAIT_DONE is enabled with `define CMD_ISSUER_TIMEOUT_EN (TIMEOUT_CYCLES >= 2).
module cmd_issuer
  import cmd_issuer_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_cmd,
  input  logic [31:0] req_arg0,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_error,
  output logic [2:0]  cmd,
  output logic [31:0] cmd_arg0,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  input  logic [31:0] cmd_res
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ISSUE     = 3'd1;
  localparam logic [2:0] S_SETTLE    = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_RESPOND   = 3'd4;

  logic [2:0]  r_state;
  logic [2:0]  r_cmd;
  logic [31:0] r_arg0;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_data;
  logic        w_full;
  logic        w_empty;
  logic        w_pop;
  req_t        w_head;
  logic        w_timeout;

  assign w_pop     = (r_state == S_IDLE) && !w_empty;
  assign req_ready = !w_full;
  assign cmd       = r_cmd;
  assign cmd_arg0  = r_arg0;
  assign cmd_valid = (r_state == S_ISSUE) && cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;

  cmd_fifo #(
    .WIDTH ($bits(req_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_push  (req_valid),
    .i_data  ({req_cmd, req_arg0}),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

`ifdef CMD_ISSUER_TIMEOUT_EN
  localparam int unsigned       TO_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT_CYCLES - 2);

  logic [TO_W-1:0] r_to_cnt;
  logic            r_rsp_error;

  // The counter is checked one step early so that RESPOND lands exactly TIMEOUT_CYCLES after SETTLE.
  assign w_timeout = (r_state == S_WAIT_DONE) && (r_to_cnt == TO_LAST);
  assign rsp_error = r_rsp_error;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_to_cnt    <= '0;
      r_rsp_error <= 1'b0;
    end else begin
      if (r_state == S_ISSUE && cmd_ready) r_to_cnt <= '0;
      else if (r_state == S_WAIT_DONE)     r_to_cnt <= r_to_cnt + 1'b1;
      if (r_state == S_WAIT_DONE) begin
        if (cmd_ready)      r_rsp_error <= 1'b0;
        else if (w_timeout) r_rsp_error <= 1'b1;
      end else if (r_state == S_RESPOND && rsp_ready) begin
        r_rsp_error <= 1'b0;
      end
    end
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
  assign w_timeout        = 1'b0;
  assign rsp_error        = 1'b0;
`endif

  // cmd/cmd_arg0 are loaded only in IDLE, so they stay put from ISSUE until RESPOND exits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cmd       <= '0;
      r_arg0      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_cmd   <= w_head.cmd;
            r_arg0  <= w_head.arg0;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (cmd_ready) r_state <= S_SETTLE;
        end
        S_SETTLE: r_state <= S_WAIT_DONE;
        S_WAIT_DONE: begin
          if (cmd_ready) begin
            r_rsp_data  <= is_read_cell(r_cmd) ? cmd_res : '0;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESPOND;
          end else if (w_timeout) begin
            r_rsp_data  <= '0;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESPOND;
          end
        end
        S_RESPOND: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_issuer.sv
// Self-checking bench for cmd_issuer: table vectors, directed corner sequences and randomized traffic
// checked against a transaction-level model of the host and the core.
module tb_cmd_issuer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_cmd;
  logic [31:0] req_arg0;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_error;
  logic [2:0]  cmd;
  logic [31:0] cmd_arg0;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_res;

  always #5 clk = ~clk;

  cmd_issuer #(
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_cmd   (req_cmd),
    .req_arg0  (req_arg0),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_error (rsp_error),
    .cmd       (cmd),
    .cmd_arg0  (cmd_arg0),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_res   (cmd_res)
  );

  // Core model: a well-formed cell address returns its alive bit. Other arguments return ~arg.
  function automatic logic [31:0] core_res(input logic [31:0] a);
    int unsigned col;
    int unsigned row;
    if (a[31:20] != 12'd0) return ~a;
    col = a[19:10];
    row = a[9:0];
    return (((col * 7) + (row * 3)) % 5 == 1) ? 32'd1 : 32'd0;
  endfunction

  assign cmd_res = core_res(cmd_arg0);

  typedef struct {
    logic [2:0]  c;
    logic [31:0] a;
  } req_s;

  typedef struct {
    logic [2:0]  c;
    logic [31:0] a;
    int          dly;
    logic [31:0] exp_data;
    int          lat;
  } vec_t;

  int          vecs = 0;
  int          errs = 0;
  int          cyc = 0;
  req_s        iss_q[$];
  req_s        cur;
  bit          outstanding = 0;
  bit          rsp_prev_pending = 0;
  logic [31:0] prev_data;
  logic        prev_err;
  bit          expect_err = 0;
  bit          pushed_now = 0;
  bit          sampled_cv = 0;
  int          pulses = 0;
  int          rsp_count = 0;
  int          rsp_first_cyc = 0;
  logic [31:0] rsp_first_data;
  int          busy = 0;
  int          core_delay = 0;
  bit          core_rand = 0;
  bit          core_hold = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic chk_true(input string name, input bit cond);
    vecs++;
    if (!cond) begin
      errs++;
      $display("FAIL %s: condition false, required true (cycle %0d)", name, cyc);
    end
  endtask

  task automatic set_hold(input bit h);
    core_hold = h;
    cmd_ready = (busy == 0) && !core_hold;
  endtask

  // One clock: observe at negedge against the model, then advance the core model after the edge.
  task automatic step();
    req_s r;
    @(negedge clk);
    cyc++;
    pushed_now = 0;
    sampled_cv = cmd_valid;
    if (cmd_valid) begin
      pulses++;
      chk("single_outstanding", {31'd0, outstanding}, 32'd0);
      chk_true("issue_has_request", iss_q.size() != 0);
      if (iss_q.size() != 0) begin
        cur = iss_q.pop_front();
        chk("issue_cmd", {29'd0, cmd}, {29'd0, cur.c});
        chk("issue_arg0", cmd_arg0, cur.a);
      end
      outstanding = 1;
    end else if (outstanding) begin
      chk("hold_cmd", {29'd0, cmd}, {29'd0, cur.c});
      chk("hold_arg0", cmd_arg0, cur.a);
    end
    if (rsp_valid) begin
      if (!rsp_prev_pending) begin
        rsp_first_cyc  = cyc;
        rsp_first_data = rsp_data;
      end else begin
        chk("rsp_data_stable", rsp_data, prev_data);
        chk("rsp_error_stable", {31'd0, rsp_error}, {31'd0, prev_err});
      end
      chk_true("rsp_has_outstanding", outstanding);
      if (rsp_ready) begin
        chk("rsp_data", rsp_data,
            expect_err ? 32'd0 : ((cur.c[1:0] == 2'd2) ? core_res(cur.a) : 32'd0));
        chk("rsp_error", {31'd0, rsp_error}, {31'd0, expect_err});
        outstanding      = 0;
        rsp_prev_pending = 0;
        rsp_count++;
      end else begin
        rsp_prev_pending = 1;
        prev_data        = rsp_data;
        prev_err         = rsp_error;
      end
    end else if (rsp_prev_pending) begin
      chk("rsp_valid_held", {31'd0, rsp_valid}, 32'd1);
      rsp_prev_pending = 0;
    end
    if (req_valid && req_ready) begin
      r.c = req_cmd;
      r.a = req_arg0;
      iss_q.push_back(r);
      pushed_now = 1;
    end
    @(posedge clk);
    #1;
    if (sampled_cv) busy = core_rand ? int'($urandom_range(0, 5)) : core_delay;
    else if (busy > 0) busy--;
    cmd_ready = (busy == 0) && !core_hold;
  endtask

  task automatic push_one(input logic [2:0] c, input logic [31:0] a, output int pcyc);
    req_cmd   = c;
    req_arg0  = a;
    req_valid = 1'b1;
    step();
    chk_true("push_accepted", pushed_now);
    pcyc      = cyc;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n, input int budget);
    int r0;
    r0 = rsp_count;
    for (int i = 0; i < budget && (rsp_count - r0) < n; i++) step();
    chk("rsp_within_budget", rsp_count - r0, n);
  endtask

  task automatic clear_model();
    iss_q.delete();
    outstanding      = 0;
    rsp_prev_pending = 0;
    busy             = 0;
    cmd_ready        = !core_hold;
  endtask

  vec_t tbl [7];

  initial begin
    int   pcyc;
    int   p0;
    int   r0;
    int   acc;
    int   sent;
    req_s bp [6];
    logic [31:0] a;

    tbl[0] = '{3'd2, 32'h0000_0C05, 0, 32'd1,          5};
    tbl[1] = '{3'd1, 32'h0000_0005, 0, 32'd0,          5};
    tbl[2] = '{3'd3, 32'h0000_1234, 2, 32'd0,          6};
    tbl[3] = '{3'd2, 32'hFFF0_0000, 4, 32'h000F_FFFF,  8};
    tbl[4] = '{3'd6, 32'h0000_0C05, 1, 32'd1,          5};
    tbl[5] = '{3'd4, 32'hDEAD_BEEF, 0, 32'd0,          5};
    tbl[6] = '{3'd2, 32'h0000_0000, 3, 32'd0,          7};

    reset     = 1'b1;
    req_valid = 1'b0;
    req_cmd   = '0;
    req_arg0  = '0;
    rsp_ready = 1'b1;
    cmd_ready = 1'b1;
    #1;
    chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
    chk("reset_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_cmd", {29'd0, cmd}, 32'd0);
    chk("reset_cmd_arg0", cmd_arg0, 32'd0);
    chk("reset_rsp_data", rsp_data, 32'd0);
    chk("reset_rsp_error", {31'd0, rsp_error}, 32'd0);
    repeat (3) step();
    reset = 1'b0;
    step();

    for (int i = 0; i < 7; i++) begin
      core_delay = tbl[i].dly;
      p0 = pulses;
      push_one(tbl[i].c, tbl[i].a, pcyc);
      wait_rsp(1, 60);
      chk("tbl_rsp_data", rsp_first_data, tbl[i].exp_data);
      chk("tbl_latency", rsp_first_cyc - pcyc, tbl[i].lat);
      chk("tbl_pulses", pulses - p0, 1);
    end

    // Seed then solve back-to-back.
    core_delay = 3;
    p0 = pulses;
    push_one(3'd3, 32'h0000_1234, pcyc);
    push_one(3'd1, 32'h0000_0005, pcyc);
    wait_rsp(2, 80);
    chk("seed_solve_pulses", pulses - p0, 2);

    // Backpressure with the response stalled.
    core_delay = 0;
    rsp_ready  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bp[i].c = 3'd2;
      a       = $urandom;
      a[31:20] = '0;
      bp[i].a = a;
    end
    p0  = pulses;
    r0  = rsp_count;
    acc = 0;
    req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      req_cmd  = bp[acc].c;
      req_arg0 = bp[acc].a;
      step();
      if (pushed_now) acc++;
    end
    chk("bp_accepted", acc, 5);
    chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
    chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("bp_pulses", pulses - p0, 1);
    rsp_ready = 1'b1;
    for (int i = 0; i < 200 && (rsp_count - r0) < 6; i++) begin
      if (acc < 6) begin
        req_cmd  = bp[acc].c;
        req_arg0 = bp[acc].a;
      end
      req_valid = (acc < 6);
      step();
      if (pushed_now) acc++;
    end
    req_valid = 1'b0;
    chk("bp_all_accepted", acc, 6);
    chk("bp_all_responses", rsp_count - r0, 6);

    // Core busy when the command reaches ISSUE.
    set_hold(1'b1);
    p0 = pulses;
    push_one(3'd2, 32'h0000_0C05, pcyc);
    repeat (12) step();
    chk("busy_no_pulse", pulses - p0, 0);
    set_hold(1'b0);
    step();
    chk("busy_issue_on_ready", {31'd0, sampled_cv}, 32'd1);
    wait_rsp(1, 40);

    // Reset while WAIT_DONE with two requests queued.
    core_delay = 20;
    push_one(3'd2, 32'h0000_0C05, pcyc);
    push_one(3'd1, 32'h0000_0777, pcyc);
    push_one(3'd3, 32'h0000_0999, pcyc);
    repeat (4) step();
    chk("pre_reset_cmd_arg0", cmd_arg0, 32'h0000_0C05);
    #2;
    reset = 1'b1;
    #1;
    chk("async_cmd", {29'd0, cmd}, 32'd0);
    chk("async_cmd_arg0", cmd_arg0, 32'd0);
    chk("async_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    chk("async_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("async_rsp_data", rsp_data, 32'd0);
    chk("async_rsp_error", {31'd0, rsp_error}, 32'd0);
    chk("async_req_ready", {31'd0, req_ready}, 32'd1);
    clear_model();
    repeat (2) step();
    reset = 1'b0;
    p0 = pulses;
    r0 = rsp_count;
    repeat (30) step();
    chk("post_reset_pulses", pulses - p0, 0);
    chk("post_reset_rsps", rsp_count - r0, 0);
    chk("post_reset_req_ready", {31'd0, req_ready}, 32'd1);

    // Randomized traffic.
    core_rand = 1;
    r0   = rsp_count;
    sent = 0;
    for (int i = 0; i < 20000; i++) begin
      if (sent >= 150 && !req_valid && (rsp_count - r0) >= 150) break;
      if (!req_valid && sent < 150 && $urandom_range(0, 2) != 0) begin
        req_cmd  = 3'($urandom_range(0, 7));
        a        = $urandom;
        if ($urandom_range(0, 1) != 0) a[31:20] = '0;
        req_arg0 = a;
        req_valid = 1'b1;
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      set_hold($urandom_range(0, 9) == 0);
      step();
      if (pushed_now) begin
        sent++;
        req_valid = 1'b0;
      end
    end
    set_hold(1'b0);
    rsp_ready = 1'b1;
    chk("rand_sent", sent, 150);
    chk("rand_responses", rsp_count - r0, 150);
    chk("rand_drained", iss_q.size(), 0);
    core_rand = 0;

`ifdef CMD_ISSUER_TIMEOUT_EN
    repeat (3) step();
    core_delay = 1000;
    expect_err = 1;
    push_one(3'd2, 32'h0000_0C05, pcyc);
    wait_rsp(1, 60);
    chk("timeout_latency", rsp_first_cyc - pcyc, 19);
    chk("timeout_rsp_data", rsp_first_data, 32'd0);
    expect_err = 0;
    reset = 1'b1;
    clear_model();
    step();
    reset = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "global timeout");
  end

endmodule
